chunked_flag_adder: RTL and testbench
=====================================

CHUNKED_FLAG_ADDER -- requirements
Module: chunked_flag_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, bits processed per cycle.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operands and mode present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, add mode only.
REQ-010 sub  input  1  0 = add, 1 = subtract (a - b).
REQ-011 out_valid  output  1  result and flags valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry out of MSB; in sub mode, 1 = no borrow.
REQ-015 zero  output  1  sum == 0.
REQ-016 neg  output  1  sum[WIDTH-1].
REQ-017 ovf  output  1  two's-complement signed overflow.

Function
REQ-018 The block SHALL have three states: IDLE, BUSY and DONE, with N = WIDTH/CHUNK.
REQ-019 in_ready SHALL be 1 only in IDLE with rst low; it SHALL be 0 in BUSY and DONE.
REQ-020 On an edge with in_valid && in_ready, the block SHALL register a, b, cin and sub, clear the chunk counter and carry, and enter BUSY.
REQ-021 Sub mode SHALL compute a + ~b + 1 and ignore cin; add mode SHALL compute a + b + cin.
REQ-022 Each BUSY cycle SHALL add one CHUNK slice (LSB slice first) with a ripple carry from the previous slice, and increment the counter.
REQ-023 On the edge completing slice N-1, the block SHALL load sum and all flags into output registers, set out_valid = 1 and enter DONE.
REQ-024 out_valid SHALL rise exactly N cycles after the acceptance edge (4 for the defaults).
REQ-025 In DONE, sum, flags and out_valid SHALL hold stable while out_ready = 0, for any duration.
REQ-026 In DONE with out_ready = 1, the next edge SHALL clear out_valid and enter IDLE; no operand is accepted on that edge.
REQ-027 sum and flags SHALL update only on the BUSY->DONE edge, and SHALL otherwise hold the last result.
REQ-028 ovf SHALL be (a_msb == b'_msb) && (raw_msb != a_msb), where b' is the effective operand (~b in sub mode).
REQ-029 zero and neg SHALL be computed on the final output value, after saturation when it is enabled.
REQ-030 Legal parameters SHALL be WIDTH >= 2, 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0; CHUNK == WIDTH gives a 1-cycle BUSY.
REQ-031 in_valid SHALL be ignored in BUSY and DONE, with no side effects.

Reset
REQ-032 While rst is high, the block SHALL be in IDLE, and in_ready, out_valid, sum, cout, zero, neg, ovf, the counter and the internal carry SHALL all be 0.
REQ-033 Assertion of rst in BUSY or DONE SHALL immediately abort the operation and discard the partial result.
REQ-034 in_ready SHALL be 1 in the first cycle after rst falls.

Configuration
REQ-035 With macro ADDER_SAT_EN defined, when ovf = 1, sum SHALL saturate to the signed maximum 0111..1 (positive overflow) or the signed minimum 1000..0 (negative overflow); ovf and cout SHALL still report the raw condition.
REQ-036 With ADDER_SAT_EN undefined, sum SHALL be the wrapped WIDTH-bit raw result.

Verification (WIDTH=16, CHUNK=4)
REQ-037 Add a=0x00FF, b=0x0001, cin=0 -> sum=0x0100, cout=0, zero=0, neg=0, ovf=0; out_valid rises 4 cycles after acceptance.
REQ-038 Add a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, zero=1, neg=0, ovf=0.
REQ-039 Add a=0x7FFF, b=0x0001 -> without SAT: sum=0x8000, neg=1, ovf=1; with ADDER_SAT_EN: sum=0x7FFF, neg=0, ovf=1.
REQ-040 Sub a=0x0003, b=0x0005 -> sum=0xFFFE, cout=0, neg=1, ovf=0, zero=0.
REQ-041 Hold out_ready=0 for 10 cycles in DONE while pulsing in_valid -> outputs stable, in_ready=0, no new capture; out_ready=1 -> IDLE on the next edge.
REQ-042 Assert rst during the 2nd BUSY cycle -> out_valid=0 and all outputs 0 immediately; in_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/chunked_flag_adder.sv
// rtl/chunked_flag_adder.sv - multi-cycle add/sub, CHUNK bits per cycle, with carry/zero/neg/ovf flags.
// Define ADDER_SAT_EN to saturate sum to the signed range on overflow.
module chunked_flag_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cin_q;
  logic             a_msb;
  logic             b_msb;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;

  logic             slice_cin;
  logic [CHUNK:0]   slice;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] res;
  logic             last;
  logic             ovf_next;

  assign in_ready = (state == S_IDLE) && !rst;

  // Operands are shifted down each cycle so the active slice is always at bit 0;
  // the result is shifted in from the top so it lands aligned after N cycles.
  always_comb begin
    slice_cin = (cnt == '0) ? cin_q : carry;
    slice     = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, slice_cin};
    acc_next  = (acc >> CHUNK) | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));
    last      = (cnt == CW'(N - 1));
    ovf_next  = (a_msb == b_msb) && (acc_next[WIDTH-1] != a_msb);
`ifdef ADDER_SAT_EN
    if (ovf_next) begin
      res = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res = acc_next;
    end
`else
    res = acc_next;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      cin_q     <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: the +1 rides in as the first-slice carry.
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            cin_q <= sub ? 1'b1 : cin;
            a_msb <= a[WIDTH-1];
            b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            cnt   <= '0;
            carry <= 1'b0;
            acc   <= '0;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          acc   <= acc_next;
          carry <= slice[CHUNK];
          if (last) begin
            sum       <= res;
            cout      <= slice[CHUNK];
            zero      <= (res == '0);
            neg       <= res[WIDTH-1];
            ovf       <= ovf_next;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_flag_adder.sv
// tb/tb_chunked_flag_adder.sv - directed bench for chunked_flag_adder (16/4 and 8/8 instances).
module tb_chunked_flag_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cout, zero, neg, ovf;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, sum8;
  logic        cout8, zero8, neg8, ovf8;

  int tests = 0;
  int fails = 0;
  int lat;

  always #5 clk = ~clk;

  chunked_flag_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .zero(zero), .neg(neg), .ovf(ovf)
  );

  chunked_flag_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(1'b0), .sub(1'b0),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .zero(zero8), .neg(neg8), .ovf(ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one operation from just after an edge and counts edges until out_valid.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                        input logic tsub, output int l);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l = 0;
    while (!out_valid && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic check_op(input string tag, input int l, input logic [15:0] es, input logic ec,
                          input logic ez, input logic en, input logic eo);
    chk({tag, ".latency"}, l, 4);
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, cout, ec);
    chk({tag, ".zero"}, zero, ez);
    chk({tag, ".neg"}, neg, en);
    chk({tag, ".ovf"}, ovf, eo);
  endtask

  task automatic release_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".out_valid_cleared"}, out_valid, 0);
    chk({tag, ".in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
    #2;
    chk("reset.in_ready", in_ready, 0);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.sum", sum, 0);
    chk("reset.flags", {cout, zero, neg, ovf}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.in_ready_after_release", in_ready, 1);
    @(posedge clk); #1;

    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
    check_op("add_carry_chain", lat, 16'h0100, 0, 0, 0, 0);
    release_op("add_carry_chain");

    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    check_op("add_wrap", lat, 16'h0000, 1, 1, 0, 0);
    release_op("add_wrap");

    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
`ifdef ADDER_SAT_EN
    check_op("add_pos_ovf", lat, 16'h7FFF, 0, 0, 0, 1);
`else
    check_op("add_pos_ovf", lat, 16'h8000, 0, 0, 1, 1);
`endif
    release_op("add_pos_ovf");

    run_op(16'h0003, 16'h0005, 1'b0, 1'b1, lat);
    check_op("sub_borrow", lat, 16'hFFFE, 0, 0, 1, 0);
    release_op("sub_borrow");

    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
`ifdef ADDER_SAT_EN
    check_op("sub_neg_ovf", lat, 16'h8000, 1, 0, 1, 1);
`else
    check_op("sub_neg_ovf", lat, 16'h7FFF, 1, 0, 0, 1);
`endif
    release_op("sub_neg_ovf");

    run_op(16'h1234, 16'h1111, 1'b1, 1'b0, lat);
    check_op("add_cin", lat, 16'h2346, 0, 0, 0, 0);
    release_op("add_cin");

    run_op(16'h0005, 16'h0005, 1'b1, 1'b1, lat);
    check_op("sub_equal_ignores_cin", lat, 16'h0000, 1, 1, 0, 0);
    release_op("sub_equal_ignores_cin");

    // Hold DONE with in_valid pulsing: nothing may move.
    run_op(16'h1357, 16'h0246, 1'b0, 1'b0, lat);
    check_op("hold", lat, 16'h159D, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 16'(i * 16'h0101);
      b = 16'hFFFF;
      @(posedge clk); #1;
      chk("hold.sum", sum, 16'h159D);
      chk("hold.out_valid", out_valid, 1);
      chk("hold.in_ready", in_ready, 0);
    end
    in_valid = 1'b1;
    a = 16'h1111;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("hold.exit_out_valid", out_valid, 0);
    chk("hold.exit_in_ready", in_ready, 1);
    chk("hold.sum_retained", sum, 16'h159D);
    @(posedge clk); #1;
    chk("hold.no_capture_on_exit", in_ready, 1);

    // Reset in the second BUSY cycle aborts and clears.
    a = 16'h4321; b = 16'h1234; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort.out_valid", out_valid, 0);
    chk("abort.sum", sum, 0);
    chk("abort.flags", {cout, zero, neg, ovf}, 0);
    chk("abort.in_ready_in_reset", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort.in_ready_after_release", in_ready, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("abort.no_result", out_valid, 0);

    // CHUNK == WIDTH: single BUSY cycle.
    a8 = 8'h80; b8 = 8'h80; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    chk("w8.busy_ready", in_ready8, 0);
    chk("w8.not_yet", out_valid8, 0);
    @(posedge clk); #1;
    chk("w8.out_valid", out_valid8, 1);
`ifdef ADDER_SAT_EN
    chk("w8.sum", sum8, 8'h80);
    chk("w8.flags", {cout8, zero8, neg8, ovf8}, 4'b1011);
`else
    chk("w8.sum", sum8, 8'h00);
    chk("w8.flags", {cout8, zero8, neg8, ovf8}, 4'b1101);
`endif
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk("w8.release", {out_valid8, in_ready8}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
